// File: rtl/bram_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// bram_prog_loader_pkg
//
// Purpose: shared definitions for the byte-stream program loader.
//   - LOADER_MAGIC : frame start byte; also re-arms a load from RUN.
//   - loader_state_t : loader FSM state encoding.
//   - csum_add : 8-bit wrapping checksum accumulate.
// -----------------------------------------------------------------------------
package bram_prog_loader_pkg;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    RUN    = 3'd5
  } loader_state_t;

  // Modulo-256 add; the carry is intentionally discarded.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage : bram_prog_loader_pkg

// File: rtl/bram_prog_loader_if.sv
// -----------------------------------------------------------------------------
// bram_prog_loader_if
//
// Purpose: bundles the UART RX byte strobe, the BRAM port-A write bus and the
// core-control/status flags of the program loader.
//
// Signals:
//   i_rx_valid      one-cycle strobe, a byte is present
//   i_rx_data[7:0]  received byte
//   o_bram_addr     BRAM port-A word address
//   o_bram_wr_data  assembled little-endian word
//   o_bram_wr_en    byte enables (4'hF for one cycle per word)
//   o_core_reset    active-high core reset
//   o_load_done     image loaded and checksum verified
//   o_load_error    sticky frame error
//
// Modports:
//   slave  : the loader (consumes bytes, drives BRAM bus and flags)
//   master : the surrounding system (drives bytes, observes the loader)
// -----------------------------------------------------------------------------
interface bram_prog_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic                  i_rx_valid;
  logic [7:0]            i_rx_data;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [31:0]           o_bram_wr_data;
  logic [3:0]            o_bram_wr_en;
  logic                  o_core_reset;
  logic                  o_load_done;
  logic                  o_load_error;

  modport slave (
    input  i_rx_valid,
    input  i_rx_data,
    output o_bram_addr,
    output o_bram_wr_data,
    output o_bram_wr_en,
    output o_core_reset,
    output o_load_done,
    output o_load_error
  );

  modport master (
    output i_rx_valid,
    output i_rx_data,
    input  o_bram_addr,
    input  o_bram_wr_data,
    input  o_bram_wr_en,
    input  o_core_reset,
    input  o_load_done,
    input  o_load_error
  );

endinterface : bram_prog_loader_if

// File: rtl/bram_prog_loader.sv
// -----------------------------------------------------------------------------
// bram_prog_loader
//
// Purpose: receives a framed program image byte by byte, assembles
// little-endian 32-bit words, writes them into BRAM port A while holding the
// core in reset, and releases the core once the 8-bit checksum matches.
//
// Frame: A5 | N[7:0] | N[15:8] | N x 4 data bytes | sum(data) mod 256
//
// Ports:
//   clk    sole clock
//   reset  synchronous, active-high
//   bus    bram_prog_loader_if.slave (RX byte strobe in, BRAM bus and
//          core_reset / load_done / load_error out; all outputs registered)
//
// Parameters:
//   SIZE            BRAM depth in words, largest legal N
//   ADDR_WIDTH      BRAM word-address width
//   TIMEOUT_CYCLES  idle cycles tolerated between bytes inside a frame
// -----------------------------------------------------------------------------
module bram_prog_loader
  import bram_prog_loader_pkg::*;
#(
  parameter int SIZE           = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  bram_prog_loader_if.slave   bus
);

  // One extra index bit so that an index equal to SIZE is representable.
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]      SIZE_L   = 17'(SIZE);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  loader_state_t         state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;       // word count N
  logic [IDX_W-1:0]      idx_q, idx_d;       // next word index
  logic [7:0]            csum_q, csum_d;
  logic [23:0]           asm_q, asm_d;       // first three bytes of a word
  logic [1:0]            bsel_q, bsel_d;     // byte position within a word
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            wr_en_q, wr_en_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  is_magic;
  logic                  timed_state;
  logic [15:0]           n_full;
  logic [16:0]           idx_inc_wide;

  assign rx_valid     = bus.i_rx_valid;
  assign rx_byte      = bus.i_rx_data;
  assign is_magic     = (rx_byte == LOADER_MAGIC);
  assign timed_state  = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                        (state_q == DATA)   || (state_q == CSUM);
  assign n_full       = {rx_byte, cnt_q[7:0]};
  // Compared against N in 17 bits so the check is independent of ADDR_WIDTH.
  assign idx_inc_wide = 17'(idx_q) + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      asm_q        <= '0;
      bsel_q       <= '0;
      tmo_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_en_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      asm_q        <= asm_d;
      bsel_q       <= bsel_d;
      tmo_q        <= tmo_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    asm_d   = asm_q;
    bsel_d  = bsel_q;
    tmo_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 4'h0;
    done_d  = done_q;
    error_d = error_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid && is_magic) begin
          state_d = CNT_LO;
          error_d = 1'b0;
          csum_d  = '0;
          idx_d   = '0;
          bsel_d  = '0;
        end
      end

      CNT_LO: begin
        if (rx_valid) begin
          cnt_d   = {8'h00, rx_byte};
          state_d = CNT_HI;
        end
      end

      CNT_HI: begin
        if (rx_valid) begin
          cnt_d = n_full;
          if (n_full == 16'd0 || {1'b0, n_full} > SIZE_L) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (rx_valid) begin
          csum_d = csum_add(csum_q, rx_byte);
          if (bsel_q == 2'd3) begin
            wr_en_d = 4'hF;
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            data_d  = {rx_byte, asm_q};
            idx_d   = idx_q + IDX_W'(1);
            bsel_d  = '0;
            if (idx_inc_wide == {1'b0, cnt_q}) begin
              state_d = CSUM;
            end
          end else begin
            // Little-endian: earlier bytes drift towards bit 0.
            asm_d  = {rx_byte, asm_q[23:8]};
            bsel_d = bsel_q + 2'd1;
          end
        end
      end

      CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RUN: begin
        if (rx_valid && is_magic) begin
          state_d = CNT_LO;
          done_d  = 1'b0;
          error_d = 1'b0;
          csum_d  = '0;
          idx_d   = '0;
          bsel_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Inter-byte timeout: overrides whatever the state logic decided, which
    // can only be "stay" because no byte arrived this cycle.
    if (timed_state && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        error_d = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Registered so the core reset changes on the same edge the state enters
  // or leaves RUN.
  assign core_reset_d = (state_d != RUN);

  assign bus.o_bram_addr    = addr_q;
  assign bus.o_bram_wr_data = data_q;
  assign bus.o_bram_wr_en   = wr_en_q;
  assign bus.o_core_reset   = core_reset_q;
  assign bus.o_load_done    = done_q;
  assign bus.o_load_error   = error_q;

endmodule : bram_prog_loader
